// File: rtl/exc_pkg.sv
// Shared types and encodings for the LEGv8 exception sequencer.
//   exc_state_t : sequencer state (NORMAL, HANDLER, HALTED)
//   CAUSE_*     : syndrome cause codes held in the low two bits of ESR
//   PCSEL_*     : next-PC source select driven to the fetch mux
package exc_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    HANDLER = 2'd1,
    HALTED  = 2'd2
  } exc_state_t;

  localparam logic [1:0] CAUSE_UNDEF = 2'b01;
  localparam logic [1:0] CAUSE_IRQ   = 2'b10;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_VEC = 2'b01;
  localparam logic [1:0] PCSEL_ELR = 2'b10;

endpackage

// File: rtl/exc_ctrl_irq_handshake.sv
// Request/acknowledge handshake with the external interrupt source.
//   clk, Reset : core clock, synchronous active-high reset
//   irq_req    : level request from the source
//   take       : sequencer is vectoring to the handler for this IRQ this cycle
//   pending    : registered request waiting to be taken
//   irq_ack    : one-cycle acknowledge, the cycle after a take
module irq_handshake (
  input  logic clk,
  input  logic Reset,
  input  logic irq_req,
  input  logic take,
  output logic pending,
  output logic irq_ack
);

  logic pending_q, pending_d;
  logic ack_wait_q, ack_wait_d;
  logic irq_ack_q, irq_ack_d;

  always_comb begin
    pending_d  = pending_q;
    ack_wait_d = ack_wait_q;
    irq_ack_d  = take;

    // A take clears the request even if irq_req is still high this cycle;
    // ack_wait then blocks re-arming until the source drops its level.
    if (take) begin
      pending_d  = 1'b0;
      ack_wait_d = 1'b1;
    end else begin
      if (irq_req && !ack_wait_q) begin
        pending_d = 1'b1;
      end
      if (!irq_req) begin
        ack_wait_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      pending_q  <= 1'b0;
      ack_wait_q <= 1'b0;
      irq_ack_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ack_wait_q <= ack_wait_d;
      irq_ack_q  <= irq_ack_d;
    end
  end

  assign pending = pending_q;
  assign irq_ack = irq_ack_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception and interrupt sequencer for the single-cycle LEGv8 core.
// Decides per cycle whether the current instruction commits, vectors to the
// handler, or returns via ERET; holds ELR/ESR and a saturating IRQ counter.
//   clk, Reset         : core clock, synchronous active-high reset
//   PC                 : address of the instruction in this cycle
//   NotAnInstr, ERet   : decoder flags
//   irq_req / irq_ack  : interrupt source handshake
//   pc_sel             : next-PC source (00 seq, 01 vector, 10 elr), combinational
//   exc_vector         : handler entry address (constant VECTOR)
//   commit_en          : 0 suppresses architectural writes, combinational
//   elr, esr           : exception link register and syndrome
//   in_handler, halt   : state indications (halt = double fault)
//   irq_count          : interrupts taken, saturating
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [63:0] VECTOR = 64'h0000_0000_0000_00D8,
  parameter int          CNT_W  = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [63:0]      PC,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic             irq_req,
  output logic             irq_ack,
  output logic [1:0]       pc_sel,
  output logic [63:0]      exc_vector,
  output logic             commit_en,
  output logic [63:0]      elr,
  output logic [63:0]      esr,
  output logic             in_handler,
  output logic             halt,
  output logic [CNT_W-1:0] irq_count
);

  exc_state_t       state_q, state_d;
  logic [63:0]      elr_q, elr_d;
  logic [63:0]      esr_q, esr_d;
  logic [CNT_W-1:0] irq_count_q, irq_count_d;
  logic             pending;
  logic             take;

  irq_handshake u_irq_handshake (
    .clk     (clk),
    .Reset   (Reset),
    .irq_req (irq_req),
    .take    (take),
    .pending (pending),
    .irq_ack (irq_ack)
  );

  always_comb begin
    state_d     = state_q;
    elr_d       = elr_q;
    esr_d       = esr_q;
    irq_count_d = irq_count_q;
    pc_sel      = PCSEL_SEQ;
    commit_en   = 1'b1;
    halt        = 1'b0;
    take        = 1'b0;

    case (state_q)
      NORMAL: begin
        // ERET outside a handler is treated as an undefined instruction.
        // UNDEF wins over a pending IRQ, which simply stays pending.
        if (NotAnInstr || ERet) begin
          pc_sel    = PCSEL_VEC;
          commit_en = 1'b0;
          elr_d     = PC;
          esr_d     = {62'd0, CAUSE_UNDEF};
          state_d   = HANDLER;
        end else if (pending) begin
          pc_sel    = PCSEL_VEC;
          commit_en = 1'b0;
          take      = 1'b1;
          elr_d     = PC;
          esr_d     = {62'd0, CAUSE_IRQ};
          if (irq_count_q != {CNT_W{1'b1}}) begin
            irq_count_d = irq_count_q + 1'b1;
          end
          state_d   = HANDLER;
        end
      end
      HANDLER: begin
        // IRQs are masked here; a fault inside the handler is fatal and
        // leaves ELR/ESR describing the original exception.
        if (NotAnInstr) begin
          commit_en = 1'b0;
          state_d   = HALTED;
        end else if (ERet) begin
          pc_sel    = PCSEL_ELR;
          state_d   = NORMAL;
        end
      end
      HALTED: begin
        halt      = 1'b1;
        commit_en = 1'b0;
      end
      default: begin
        state_d = NORMAL;
      end
    endcase

    if (Reset) begin
      pc_sel    = PCSEL_SEQ;
      commit_en = 1'b0;
      take      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= NORMAL;
      elr_q       <= 64'd0;
      esr_q       <= 64'd0;
      irq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      elr_q       <= elr_d;
      esr_q       <= esr_d;
      irq_count_q <= irq_count_d;
    end
  end

  assign exc_vector = VECTOR;
  assign elr        = elr_q;
  assign esr        = esr_q;
  assign irq_count  = irq_count_q;
  assign in_handler = (state_q == HANDLER);

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic [63:0] PC;
  logic        NotAnInstr;
  logic        ERet;
  logic        irq_req;
  logic        irq_ack;
  logic [1:0]  pc_sel;
  logic [63:0] exc_vector;
  logic        commit_en;
  logic [63:0] elr;
  logic [63:0] esr;
  logic        in_handler;
  logic        halt;
  logic [1:0]  irq_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exc_ctrl #(
    .VECTOR (64'h0000_0000_0000_00D8),
    .CNT_W  (2)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .PC         (PC),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .pc_sel     (pc_sel),
    .exc_vector (exc_vector),
    .commit_en  (commit_en),
    .elr        (elr),
    .esr        (esr),
    .in_handler (in_handler),
    .halt       (halt),
    .irq_count  (irq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; PC = 64'h0; NotAnInstr = 1'b0; ERet = 1'b0; irq_req = 1'b0;
    tick();
    settle();
    chk("rst_pc_sel", 64'(pc_sel), 64'h0);
    chk("rst_commit", 64'(commit_en), 64'h0);
    tick();

    // Reset values after release
    Reset = 1'b0;
    settle();
    chk("rv_pc_sel", 64'(pc_sel), 64'h0);
    chk("rv_commit", 64'(commit_en), 64'h1);
    chk("rv_elr", elr, 64'h0);
    chk("rv_esr", esr, 64'h0);
    chk("rv_in_handler", 64'(in_handler), 64'h0);
    chk("rv_halt", 64'(halt), 64'h0);
    chk("rv_irq_count", 64'(irq_count), 64'h0);
    chk("rv_irq_ack", 64'(irq_ack), 64'h0);
    chk("rv_vector", exc_vector, 64'hD8);

    // Undefined opcode at 0x40
    tick();
    PC = 64'h40; NotAnInstr = 1'b1;
    settle();
    chk("ud_pc_sel", 64'(pc_sel), 64'h1);
    chk("ud_commit", 64'(commit_en), 64'h0);
    tick();
    PC = 64'hD8; NotAnInstr = 1'b0;
    settle();
    chk("ud_elr", elr, 64'h40);
    chk("ud_esr", esr, 64'h1);
    chk("ud_in_handler", 64'(in_handler), 64'h1);
    chk("ud_h_commit", 64'(commit_en), 64'h1);
    chk("ud_h_pc_sel", 64'(pc_sel), 64'h0);
    tick();
    PC = 64'hDC; ERet = 1'b1;
    settle();
    chk("ud_eret_pc_sel", 64'(pc_sel), 64'h2);
    chk("ud_eret_commit", 64'(commit_en), 64'h1);
    tick();
    PC = 64'h40; ERet = 1'b0;
    settle();
    chk("ud_ret_in_handler", 64'(in_handler), 64'h0);
    chk("ud_ret_pc_sel", 64'(pc_sel), 64'h0);

    // IRQ handshake: request raised at PC 0x100, taken at 0x104
    tick();
    PC = 64'h100; irq_req = 1'b1;
    settle();
    chk("irq_req_cycle_pc_sel", 64'(pc_sel), 64'h0);
    tick();
    PC = 64'h104;
    settle();
    chk("irq_take_pc_sel", 64'(pc_sel), 64'h1);
    chk("irq_take_commit", 64'(commit_en), 64'h0);
    chk("irq_take_ack", 64'(irq_ack), 64'h0);
    tick();
    PC = 64'hD8;
    settle();
    chk("irq_elr", elr, 64'h104);
    chk("irq_esr", esr, 64'h2);
    chk("irq_ack_pulse", 64'(irq_ack), 64'h1);
    chk("irq_count1", 64'(irq_count), 64'h1);
    chk("irq_in_handler", 64'(in_handler), 64'h1);
    tick();
    PC = 64'hDC; ERet = 1'b1;
    settle();
    chk("irq_ack_low", 64'(irq_ack), 64'h0);
    tick();
    PC = 64'h104; ERet = 1'b0;
    settle();
    chk("irq_held_no_retake", 64'(pc_sel), 64'h0);
    chk("irq_held_commit", 64'(commit_en), 64'h1);
    tick();
    PC = 64'h108;
    settle();
    chk("irq_held_count", 64'(irq_count), 64'h1);
    chk("irq_held_in_handler", 64'(in_handler), 64'h0);
    irq_req = 1'b0;
    tick();

    // Simultaneous UNDEF and pending IRQ
    PC = 64'h200; irq_req = 1'b1;
    tick();
    PC = 64'h204; irq_req = 1'b0; NotAnInstr = 1'b1;
    settle();
    chk("sim_pc_sel", 64'(pc_sel), 64'h1);
    tick();
    PC = 64'hD8; NotAnInstr = 1'b0; ERet = 1'b1;
    settle();
    chk("sim_esr_undef", esr, 64'h1);
    chk("sim_elr", elr, 64'h204);
    chk("sim_no_ack", 64'(irq_ack), 64'h0);
    chk("sim_count", 64'(irq_count), 64'h1);
    chk("sim_eret_pc_sel", 64'(pc_sel), 64'h2);
    tick();
    PC = 64'h204; ERet = 1'b0;
    settle();
    chk("sim_irq_after_eret_pc_sel", 64'(pc_sel), 64'h1);
    chk("sim_irq_after_eret_commit", 64'(commit_en), 64'h0);
    tick();
    PC = 64'hD8;
    settle();
    chk("sim_irq_esr", esr, 64'h2);
    chk("sim_irq_elr", elr, 64'h204);
    chk("sim_irq_ack", 64'(irq_ack), 64'h1);
    chk("sim_irq_count", 64'(irq_count), 64'h2);

    // Double fault inside the handler
    NotAnInstr = 1'b1;
    settle();
    chk("df_commit", 64'(commit_en), 64'h0);
    chk("df_halt_not_yet", 64'(halt), 64'h0);
    tick();
    NotAnInstr = 1'b0; ERet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("df_halt", 64'(halt), 64'h1);
      chk("df_hold_commit", 64'(commit_en), 64'h0);
      chk("df_hold_pc_sel", 64'(pc_sel), 64'h0);
      tick();
    end
    chk("df_esr", esr, 64'h2);
    chk("df_elr", elr, 64'h204);
    ERet = 1'b0; Reset = 1'b1;
    settle();
    chk("df_rst_commit", 64'(commit_en), 64'h0);
    tick();
    Reset = 1'b0;
    settle();
    chk("df_rst_halt", 64'(halt), 64'h0);
    chk("df_rst_in_handler", 64'(in_handler), 64'h0);
    chk("df_rst_elr", elr, 64'h0);
    chk("df_rst_esr", esr, 64'h0);
    chk("df_rst_count", 64'(irq_count), 64'h0);
    chk("df_rst_commit_after", 64'(commit_en), 64'h1);

    // Counter saturation with a 2-bit counter
    for (int r = 0; r < 4; r++) begin
      PC = 64'h300; irq_req = 1'b1;
      tick();
      PC = 64'h304; irq_req = 1'b0;
      settle();
      chk("sat_take", 64'(pc_sel), 64'h1);
      tick();
      PC = 64'hD8;
      settle();
      chk("sat_count", 64'(irq_count), (r < 3) ? 64'(r + 1) : 64'h3);
      ERet = 1'b1;
      tick();
      ERet = 1'b0;
    end

    // Reset in the middle of a handler
    PC = 64'h400; irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    tick();
    settle();
    chk("mid_in_handler", 64'(in_handler), 64'h1);
    chk("mid_count", 64'(irq_count), 64'h3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    settle();
    chk("mid_rst_in_handler", 64'(in_handler), 64'h0);
    chk("mid_rst_count", 64'(irq_count), 64'h0);
    chk("mid_rst_ack", 64'(irq_ack), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
